// File: rtl/nios_wallet_cpu_mul_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : nios_wallet_cpu_mul_pkg
//  Purpose  : Shared definitions for the nios_wallet multiply sequencer:
//             operation encodings, sequencer state encoding and the
//             operand/partial-product slice widths.
//  Ports    : none (package)
//  Revision : 1.0 - initial release
// ============================================================================
package nios_wallet_cpu_mul_pkg;

    // Operand word and the half-word slice the 16x16 cell works on.
    localparam int WORD_W  = 32;
    localparam int SLICE_W = 16;

    // Multiply operation encodings as seen on the op input.
    typedef enum logic [1:0] {
        OP_MUL    = 2'd0,   // low 32 bits of the product
        OP_MULXUU = 2'd1,   // high word, unsigned x unsigned
        OP_MULXSU = 2'd2,   // high word, signed A x unsigned B
        OP_MULXSS = 2'd3    // high word, signed x signed
    } mul_op_e;

    // Sequencer states.
    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LO   = 3'd1,     // cell fed with the low-slice operands
        ST_HI   = 3'd2,     // low-pass products visible, high pass issued
        ST_SUM  = 3'd3,     // hh visible, high word assembled
        ST_DONE = 3'd4      // result presented for one cycle
    } mul_state_e;

endpackage
`default_nettype wire

// File: rtl/nios_wallet_cpu_mul_seq_if.sv
`default_nettype none
// ============================================================================
//  Module   : nios_wallet_cpu_mul_seq_if
//  Purpose  : Request/response bundle between the E-stage operand latch
//             (master) and the multiply sequencer (slave).
//  Signals  : start, op[1:0], src_a[31:0], src_b[31:0]  master -> slave
//             busy, done, result[31:0]                   slave  -> master
//  Revision : 1.0 - initial release
// ============================================================================
interface nios_wallet_cpu_mul_seq_if;

    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic        done;
    logic [31:0] result;

    modport master (
        output start, op, src_a, src_b,
        input  busy, done, result
    );

    modport slave (
        input  start, op, src_a, src_b,
        output busy, done, result
    );

endinterface
`default_nettype wire

// File: rtl/nios_wallet_cpu_mul_fixup.sv
`default_nettype none
// ============================================================================
//  Module   : nios_wallet_cpu_mul_fixup
//  Purpose  : Combinational product assembly. Adds the four 16x16 partial
//             products into a full 64-bit unsigned product and applies the
//             signed correction to its high word for MULXSU / MULXSS.
//  Ports    : ll, lh, hl, hh [31:0]  partial products (a_lo*b_lo, a_lo*b_hi,
//                                    a_hi*b_lo, a_hi*b_hi)
//             a, b [31:0]            original operands (for sign fixup)
//             op                     operation encoding
//             lo [31:0]              product bits 31:0
//             hi [31:0]              corrected product bits 63:32
//  Revision : 1.0 - initial release
// ============================================================================
module nios_wallet_cpu_mul_fixup
    import nios_wallet_cpu_mul_pkg::*;
(
    input  logic [31:0] ll,
    input  logic [31:0] lh,
    input  logic [31:0] hl,
    input  logic [31:0] hh,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  mul_op_e     op,
    output logic [31:0] lo,
    output logic [31:0] hi
);

    localparam int PAD_HI = 2 * WORD_W - WORD_W - SLICE_W;

    logic [63:0] sum64;
    logic [31:0] corr_a;
    logic [31:0] corr_b;

    always_comb begin
        // Middle terms are shifted by one slice; all carries kept in 64 bits.
        sum64 = {{WORD_W{1'b0}}, ll}
              + {{PAD_HI{1'b0}}, lh, {SLICE_W{1'b0}}}
              + {{PAD_HI{1'b0}}, hl, {SLICE_W{1'b0}}}
              + {hh, {WORD_W{1'b0}}};

        // A negative operand read as unsigned is too large by 2^32, which
        // inflates the high word by exactly the other operand.
        corr_a = '0;
        corr_b = '0;
        if ((op == OP_MULXSU) || (op == OP_MULXSS)) begin
            corr_a = a[31] ? b : '0;
        end
        if (op == OP_MULXSS) begin
            corr_b = b[31] ? a : '0;
        end

        lo = sum64[31:0];
        hi = sum64[63:32] - corr_a - corr_b;
    end

endmodule
`default_nettype wire

// File: rtl/nios_wallet_cpu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : nios_wallet_cpu_mul_seq
//  Purpose  : Multiply sequencer for the nios_wallet CPU. Drives an external
//             registered 16x16 three-partial-product multiplier cell over one
//             pass (MUL) or two passes (MULXUU/MULXSU/MULXSS) and assembles
//             the 32-bit result word.
//  Ports    : clk                   CPU clock
//             reset_n               asynchronous active-low reset
//             bus (slave)           start/op/src_a/src_b in,
//                                   busy/done/result out
//             cell_src1/cell_src2   operands to the cell
//             cell_en               cell register enable
//             cell_p1/p2/p3         registered partial products from cell
//  Revision : 1.0 - initial release
// ============================================================================
module nios_wallet_cpu_mul_seq
    import nios_wallet_cpu_mul_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset_n,
    nios_wallet_cpu_mul_seq_if.slave   bus,
    output logic [31:0]                cell_src1,
    output logic [31:0]                cell_src2,
    output logic                       cell_en,
    input  logic [31:0]                cell_p1,
    input  logic [31:0]                cell_p2,
    input  logic [31:0]                cell_p3
);

    mul_state_e  state;
    mul_state_e  state_next;

    logic [31:0] a_r;
    logic [31:0] b_r;
    mul_op_e     op_r;
    logic [31:0] ll_r;
    logic [31:0] lh_r;
    logic [31:0] hl_r;
    logic [31:0] result_r;

    logic        capture_lo;
    logic        load_result;

    logic [31:0] fix_ll;
    logic [31:0] fix_lh;
    logic [31:0] fix_hl;
    logic [31:0] fix_hh;
    logic [31:0] fix_lo;
    logic [31:0] fix_hi;
    logic [31:0] result_next;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next state and cell drive
    // ------------------------------------------------------------------
    always_comb begin
        state_next  = state;
        cell_en     = 1'b0;
        cell_src1   = '0;
        cell_src2   = '0;
        capture_lo  = 1'b0;
        load_result = 1'b0;

        case (state)
            ST_IDLE: begin
                if (bus.start) begin
                    state_next = ST_LO;
                end
            end
            ST_LO: begin
                cell_en    = 1'b1;
                cell_src1  = a_r;
                cell_src2  = b_r;
                state_next = ST_HI;
            end
            ST_HI: begin
                capture_lo = 1'b1;
                if (op_r == OP_MUL) begin
                    load_result = 1'b1;
                    state_next  = ST_DONE;
                end else begin
                    // Only p1 of this pass is used: the upper halves of the
                    // operands are zero, so p2/p3 come back as zero.
                    cell_en    = 1'b1;
                    cell_src1  = {{(WORD_W - SLICE_W){1'b0}}, a_r[31:16]};
                    cell_src2  = {{(WORD_W - SLICE_W){1'b0}}, b_r[31:16]};
                    state_next = ST_SUM;
                end
            end
            ST_SUM: begin
                load_result = 1'b1;
                state_next  = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Product assembly. In HI the low-pass products come straight from the
    // cell (MUL finishes there); in SUM they come from the captured copies
    // and the cell output now carries hh.
    // ------------------------------------------------------------------
    always_comb begin
        if (state == ST_HI) begin
            fix_ll = cell_p1;
            fix_lh = cell_p2;
            fix_hl = cell_p3;
            fix_hh = '0;
        end else begin
            fix_ll = ll_r;
            fix_lh = lh_r;
            fix_hl = hl_r;
            fix_hh = cell_p1;
        end
    end

    nios_wallet_cpu_mul_fixup u_fixup (
        .ll (fix_ll),
        .lh (fix_lh),
        .hl (fix_hl),
        .hh (fix_hh),
        .a  (a_r),
        .b  (b_r),
        .op (op_r),
        .lo (fix_lo),
        .hi (fix_hi)
    );

    assign result_next = (op_r == OP_MUL) ? fix_lo : fix_hi;

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            a_r      <= '0;
            b_r      <= '0;
            op_r     <= OP_MUL;
            ll_r     <= '0;
            lh_r     <= '0;
            hl_r     <= '0;
            result_r <= '0;
        end else begin
            if ((state == ST_IDLE) && bus.start) begin
                a_r  <= bus.src_a;
                b_r  <= bus.src_b;
                op_r <= mul_op_e'(bus.op);
            end
            if (capture_lo) begin
                ll_r <= cell_p1;
                lh_r <= cell_p2;
                hl_r <= cell_p3;
            end
            if (load_result) begin
                result_r <= result_next;
            end
        end
    end

    assign bus.busy   = (state != ST_IDLE);
    assign bus.done   = (state == ST_DONE);
    assign bus.result = result_r;

endmodule
`default_nettype wire

// File: tb/tb_nios_wallet_cpu_mul_seq.sv
`default_nettype none
// ============================================================================
//  Module   : tb_nios_wallet_cpu_mul_seq
//  Purpose  : Self-checking bench for the multiply sequencer with a
//             behavioural registered 16x16 cell and a result scoreboard.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_nios_wallet_cpu_mul_seq;

    logic        clk;
    logic        reset_n;
    logic [31:0] cell_src1;
    logic [31:0] cell_src2;
    logic        cell_en;
    logic [31:0] cell_p1;
    logic [31:0] cell_p2;
    logic [31:0] cell_p3;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] sb_q[$];

    nios_wallet_cpu_mul_seq_if bus ();

    nios_wallet_cpu_mul_seq dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .bus       (bus.slave),
        .cell_src1 (cell_src1),
        .cell_src2 (cell_src2),
        .cell_en   (cell_en),
        .cell_p1   (cell_p1),
        .cell_p2   (cell_p2),
        .cell_p3   (cell_p3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural multiplier cell: registered, one-cycle latency, enable-gated.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cell_p1 <= '0;
            cell_p2 <= '0;
            cell_p3 <= '0;
        end else if (cell_en) begin
            cell_p1 <= {16'b0, cell_src1[15:0]}  * {16'b0, cell_src2[15:0]};
            cell_p2 <= {16'b0, cell_src1[15:0]}  * {16'b0, cell_src2[31:16]};
            cell_p3 <= {16'b0, cell_src1[31:16]} * {16'b0, cell_src2[15:0]};
        end
    end

    // Reference product from full 64-bit multiplication.
    function automatic logic [31:0] model(input logic [1:0] o,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] p;
        case (o)
            2'd0:    p = {32'b0, a} * {32'b0, b};
            2'd1:    p = {32'b0, a} * {32'b0, b};
            2'd2:    p = {{32{a[31]}}, a} * {32'b0, b};
            default: p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        endcase
        return (o == 2'd0) ? p[31:0] : p[63:32];
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] obs,
                            input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Issue one operation from an IDLE cycle (called #1 after an edge) and
    // follow it to completion. Returns #1 into the cycle after done, where
    // the sequencer is IDLE again and a new start is accepted.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a,
                          input logic [31:0] b, input bit repulse);
        logic [31:0] exp;
        int          cyc;
        int          lat_exp;
        lat_exp = (o == 2'd0) ? 3 : 4;
        bus.start = 1'b1;
        bus.op    = o;
        bus.src_a = a;
        bus.src_b = b;
        sb_q.push_back(model(o, a, b));
        @(posedge clk); #1;
        bus.start = 1'b0;
        cyc = 1;
        check_eq("lo_cell_en", 32'(cell_en), 32'd1);
        check_eq("lo_cell_src1", cell_src1, a);
        while (!bus.done && cyc < 10) begin
            check_eq("busy", 32'(bus.busy), 32'd1);
            if (repulse && cyc == 1) begin
                bus.start = 1'b1;
                bus.op    = ~o;
                bus.src_a = a ^ 32'h1234_5678;
                bus.src_b = b + 32'd7;
            end else begin
                bus.start = 1'b0;
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.start = 1'b0;
        exp = sb_q.pop_front();
        if (!bus.done) begin
            check_eq("done_timeout", 32'(bus.done), 32'd1);
        end else begin
            check_eq("latency", 32'(cyc), 32'(lat_exp));
            check_eq("busy_in_done", 32'(bus.busy), 32'd1);
            check_eq($sformatf("result op%0d a=%08h b=%08h", o, a, b),
                     bus.result, exp);
        end
        @(posedge clk); #1;
        check_eq("busy_after", 32'(bus.busy), 32'd0);
        check_eq("done_after", 32'(bus.done), 32'd0);
        check_eq("result_hold", bus.result, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n   = 1'b0;
        bus.start = 1'b0;
        bus.op    = 2'd0;
        bus.src_a = '0;
        bus.src_b = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_busy", 32'(bus.busy), 32'd0);
        check_eq("rst_done", 32'(bus.done), 32'd0);
        check_eq("rst_result", bus.result, 32'd0);
        check_eq("rst_cell_en", 32'(cell_en), 32'd0);
        check_eq("rst_cell_src1", cell_src1, 32'd0);
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;

        // Directed corner cases.
        run_op(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        run_op(2'd1, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'd3, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'd2, 32'h8000_0000, 32'h8000_0000, 1'b0);
        run_op(2'd0, 32'h0001_0000, 32'h0001_0000, 1'b0);
        run_op(2'd1, 32'h0001_0000, 32'h0001_0000, 1'b0);

        // Start re-pulsed while busy is ignored; the following op is issued
        // in the cycle right after done.
        run_op(2'd0, 32'h0000_1234, 32'h0000_5678, 1'b1);
        run_op(2'd3, 32'h8765_4321, 32'h1357_9BDF, 1'b1);
        run_op(2'd2, 32'h7FFF_0001, 32'hC000_00FF, 1'b0);

        // Reset taken in SUM aborts the operation with no done pulse.
        bus.start = 1'b1;
        bus.op    = 2'd1;
        bus.src_a = 32'hFFFF_FFFF;
        bus.src_b = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        bus.start = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        check_eq("sum_busy", 32'(bus.busy), 32'd1);
        check_eq("sum_cell_en", 32'(cell_en), 32'd0);
        reset_n = 1'b0;
        #1;
        check_eq("abort_busy", 32'(bus.busy), 32'd0);
        check_eq("abort_done", 32'(bus.done), 32'd0);
        check_eq("abort_result", bus.result, 32'd0);
        check_eq("abort_cell_en", 32'(cell_en), 32'd0);
        repeat (2) begin
            @(posedge clk); #1;
            check_eq("abort_no_done", 32'(bus.done), 32'd0);
        end
        @(negedge clk) reset_n = 1'b1;
        @(posedge clk); #1;
        check_eq("post_rst_done", 32'(bus.done), 32'd0);
        run_op(2'd0, 32'd3, 32'd5, 1'b0);

        // A few random operands across all ops.
        for (int i = 0; i < 8; i++) begin
            run_op(2'(i % 4), $urandom, $urandom, 1'b0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
